// File: rtl/sine_seq_pkg.sv
// Shared types for the sine table sequencer: FSM states, default latency/buffer sizes.
// Pure declarations; no latency and no flow control of its own.
package sine_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int RD_LATENCY_DEF = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    // Width able to hold any value 0..depth (occupancy, credit, in-flight count).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding returned samples; head is visible the cycle after the push.
// Push and pop may coincide when full or empty; a pop on empty and a push on full without pop are dropped.
module sample_fifo
    import sine_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sine_table_sequencer.sv
// Phase-accumulator read controller for a registered sine RAM; first sample valid RD_LATENCY+1 cycles after issue.
// Reads are issued only against free FIFO credit, so a stalled consumer throttles issue without loss.
module sine_table_sequencer
    import sine_seq_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int PHASE_W    = 24,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [15:0]        burst_len,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_en,
    output logic               ram_regce,
    input  logic [DATA_W-1:0]  ram_dout,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready
);

    localparam int CW = cnt_w(FIFO_DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  phase_nxt;
    logic [PHASE_W-1:0]  tw_q;
    logic [15:0]         blen_q;
    logic [15:0]         issued;
    logic [15:0]         issued_nxt;
    logic                load;
    logic                issue;
    logic [RD_LATENCY-1:0] tag_sr;
    logic [CW-1:0]       in_flight;
    logic [CW-1:0]       credit;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CW'(tag_sr[i]);
        end
    end

    // Every outstanding read already owns a FIFO slot, so occupancy + in-flight never exceeds depth.
    assign credit = fifo_full ? '0 : (CW'(FIFO_DEPTH) - fifo_count - in_flight);

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        issued_nxt = issued;
        load       = 1'b0;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt  = RUN;
                    load       = 1'b1;
                    phase_nxt  = '0;
                    issued_nxt = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = DRAIN;
                end else if (credit != '0) begin
                    issue      = 1'b1;
                    phase_nxt  = phase + tw_q;
                    issued_nxt = issued + 16'd1;
                    if ((blen_q != '0) && (issued_nxt == blen_q)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((in_flight == '0) && fifo_empty) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            phase  <= '0;
            issued <= '0;
            tw_q   <= '0;
            blen_q <= '0;
            tag_sr <= '0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            issued <= issued_nxt;
            tag_sr <= (tag_sr << 1) | RD_LATENCY'(issue);
            if (load) begin
                tw_q   <= tuning_word;
                blen_q <= burst_len;
            end
        end
    end

    assign busy      = (state != IDLE) && !done;
    assign ram_en    = issue;
    assign ram_addr  = phase[PHASE_W-1 -: ADDR_W];
    assign ram_regce = 1'b1;

    // The oldest tag marks the cycle in which ram_dout carries that read's data.
    assign fifo_push = tag_sr[RD_LATENCY-1];
    assign fifo_pop  = m_valid && m_ready;
    assign m_valid   = !fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (ram_dout),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sine_table_sequencer.sv
// Directed bench with a registered RAM model and a scoreboard of expected ROM samples.
module tb_sine_table_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [23:0] tuning_word;
    logic [15:0] burst_len;
    logic        busy;
    logic        done;
    logic [9:0]  ram_addr;
    logic        ram_en;
    logic        ram_regce;
    logic [7:0]  ram_dout;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    always #5 clk = ~clk;

    sine_table_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .tuning_word (tuning_word),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_en      (ram_en),
        .ram_regce   (ram_regce),
        .ram_dout    (ram_dout),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    // Two-stage registered RAM: array read on enable, then output register.
    logic [7:0] rom [1024];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (ram_en) ram_q <= rom[ram_addr];
        if (ram_regce) ram_dout <= ram_q;
    end

    int compared = 0;
    int mismatched = 0;

    int cyc, n_issue, n_pop, n_done, n_vld;
    int first_en, first_vld, first_pop, last_pop, done_cyc;
    int at_stop;
    logic [23:0] exp_phase;
    logic [23:0] cur_tw;
    logic [7:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input logic [23:0] tw);
        exp_phase = '0;
        cur_tw    = tw;
        n_issue   = 0;
        n_pop     = 0;
        n_done    = 0;
        n_vld     = 0;
        first_en  = -1;
        first_vld = -1;
        first_pop = -1;
        last_pop  = -1;
        done_cyc  = -1;
        exp_q.delete();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (ram_en) begin
                    chk("ram_addr", 32'(ram_addr), 32'(exp_phase[23:14]));
                    exp_q.push_back(rom[exp_phase[23:14]]);
                    exp_phase = exp_phase + cur_tw;
                    if (first_en < 0) first_en = cyc;
                    n_issue++;
                end
                if (m_valid) begin
                    n_vld++;
                    if (first_vld < 0) first_vld = cyc;
                end
                if (m_valid && m_ready) begin
                    chk("sample_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    n_pop++;
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [23:0] tw, input logic [15:0] bl);
        tick();
        clear_model(tw);
        tuning_word = tw;
        burst_len   = bl;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop    = 1'b1;
        at_stop = n_issue;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (n_done == 0 && c < budget) begin
            tick();
            c++;
        end
        repeat (2) tick();
        chk("done_pulses", 32'(n_done), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'((i * 37 + (i >> 5) * 11 + 3) & 255);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        tuning_word = '0; burst_len = '0; m_ready = 1'b1; cyc = 0; at_stop = 0;
        clear_model('0);
        fork
            monitor();
        join_none
        repeat (2) tick();
        check_idle_outputs("reset");
        chk("reset_regce", 32'(ram_regce), 32'd1);
        rst_n = 1'b1;
        tick();

        // 1: +1 address step, 4 samples, consumer always ready
        do_start(24'h004000, 16'd4);
        chk("t1_busy_running", 32'(busy), 32'd1);
        wait_done(50);
        chk("t1_issues", 32'(n_issue), 32'd4);
        chk("t1_pops", 32'(n_pop), 32'd4);
        chk("t1_first_valid_latency", 32'(first_vld - first_en), 32'd3);
        chk("t1_back_to_back", 32'(last_pop - first_pop), 32'd3);
        chk("t1_done_after_last_pop", 32'(done_cyc - last_pop), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_leftover", 32'(exp_q.size()), 32'd0);

        // 2: +64 step wraps the table
        do_start(24'h100000, 16'd20);
        wait_done(100);
        chk("t2_issues", 32'(n_issue), 32'd20);
        chk("t2_pops", 32'(n_pop), 32'd20);
        chk("t2_leftover", 32'(exp_q.size()), 32'd0);

        // 3: continuous with consumer stalled, then resumed
        m_ready = 1'b0;
        do_start(24'h00C000, 16'd0);
        repeat (12) tick();
        chk("t3_issues_while_stalled", 32'(n_issue), 32'd4);
        chk("t3_pops_while_stalled", 32'(n_pop), 32'd0);
        chk("t3_valid_while_stalled", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        repeat (10) tick();
        pulse_stop();
        wait_done(50);
        chk("t3_no_issue_after_stop", 32'(n_issue), 32'(at_stop));
        chk("t3_resumed", 32'(n_issue > 4), 32'd1);
        chk("t3_all_delivered", 32'(n_pop), 32'(n_issue));
        chk("t3_leftover", 32'(exp_q.size()), 32'd0);

        // 4: continuous, stop after 7 issues
        do_start(24'h004000, 16'd0);
        begin
            int c = 0;
            while (n_issue < 7 && c < 50) begin
                tick();
                c++;
            end
        end
        pulse_stop();
        chk("t4_issues_at_stop", 32'(at_stop), 32'd7);
        wait_done(50);
        chk("t4_issues", 32'(n_issue), 32'd7);
        chk("t4_pops", 32'(n_pop), 32'd7);
        chk("t4_busy_after", 32'(busy), 32'd0);

        // 5: start while running is ignored; start+stop together in IDLE is ignored
        do_start(24'h004000, 16'd6);
        tick();
        tuning_word = 24'h200000;
        burst_len   = 16'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_done(50);
        chk("t5_issues", 32'(n_issue), 32'd6);
        chk("t5_pops", 32'(n_pop), 32'd6);
        clear_model(24'h004000);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_busy_after_start_stop", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("t5_idle_issues", 32'(n_issue), 32'd0);
        chk("t5_idle_done", 32'(n_done), 32'd0);

        // 6: reset with two reads in flight, then a clean run
        do_start(24'h004000, 16'd0);
        begin
            int c = 0;
            while (n_issue < 2 && c < 20) begin
                tick();
                c++;
            end
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_in_reset");
        tick();
        rst_n = 1'b1;
        clear_model(24'h004000);
        repeat (6) tick();
        chk("t6_no_stale_valid", 32'(n_vld), 32'd0);
        chk("t6_no_issue", 32'(n_issue), 32'd0);
        do_start(24'h004000, 16'd3);
        wait_done(50);
        chk("t6_pops", 32'(n_pop), 32'd3);
        chk("t6_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
